// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader: button bit positions
// within the shifted-in byte and the frame sequencer state type.
package nes_pkg;

  localparam int unsigned NUM_BTNS   = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_DONE
  } nes_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running protocol tick generator: one-cycle tick every DIV enabled cycles.
// While en is low the count freezes, shifting the tick phase by those cycles.
module tick_divider #(
  parameter int unsigned DIV = 56
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_top;

  always_comb begin
    at_top = (cnt_q == CW'(DIV - 1));
    cnt_d  = cnt_q;
    if (en) begin
      cnt_d = at_top ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en & at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: periodically latches the pad, shifts in eight button
// bits and publishes them, plus a filtered D-pad, with a one-cycle valid strobe.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 56,
  parameter int unsigned LATCH_TICKS = 11,
  parameter int unsigned POLL_TICKS  = 14880
) (
  input  logic       inputclk,
  input  logic       reset_b,
  input  logic       data,
  output logic       clklatch,
  output logic       clkout,
  output logic [7:0] buttons,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       valid
);

  localparam int unsigned CNT_MAX = (POLL_TICKS > LATCH_TICKS) ? POLL_TICKS : LATCH_TICKS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  nes_state_e state_q, state_d;

  logic [CNT_W-1:0]    poll_q, poll_d;
  logic [2:0]          bit_q, bit_d;
  logic [NUM_BTNS-1:0] shift_q, shift_d;
  logic [NUM_BTNS-1:0] buttons_q, buttons_d;
  logic                sync1_q, sync2_q;
  logic                clklatch_q, clklatch_d;
  logic                clkout_q, clkout_d;
  logic                up_q, up_d;
  logic                down_q, down_d;
  logic                left_q, left_d;
  logic                right_q, right_d;
  logic                valid_q, valid_d;
  logic                tick;
  logic                tick_en;

  // Freezing the divider during DONE makes that cycle add to the frame period.
  assign tick_en = (state_q != ST_DONE);

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (inputclk),
    .rst_n (reset_b),
    .en    (tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    up_d      = up_q;
    down_d    = down_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (poll_q == CNT_W'(POLL_TICKS - 1)) begin
            poll_d  = '0;
            state_d = ST_LATCH;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        // poll counter doubles as the latch-width counter
        if (tick) begin
          if (poll_q == CNT_W'(LATCH_TICKS - 1)) begin
            poll_d     = '0;
            shift_d[0] = ~sync2_q;
            bit_d      = 3'd1;
            state_d    = ST_CLK_HI;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      ST_CLK_HI: begin
        if (tick) begin
          state_d = ST_CLK_LO;
        end
      end
      ST_CLK_LO: begin
        if (tick) begin
          shift_d[bit_q] = ~sync2_q;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_CLK_HI;
          end
        end
      end
      ST_DONE: begin
        buttons_d = shift_q;
        up_d      = shift_q[BTN_UP]    & ~shift_q[BTN_DOWN];
        down_d    = shift_q[BTN_DOWN]  & ~shift_q[BTN_UP];
        left_d    = shift_q[BTN_LEFT]  & ~shift_q[BTN_RIGHT];
        right_d   = shift_q[BTN_RIGHT] & ~shift_q[BTN_LEFT];
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clklatch_d = (state_d == ST_LATCH);
    clkout_d   = (state_d == ST_CLK_HI);
  end

  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      poll_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      clklatch_q <= 1'b0;
      clkout_q   <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      sync1_q    <= data;
      sync2_q    <= sync1_q;
      clklatch_q <= clklatch_d;
      clkout_q   <= clkout_d;
      up_q       <= up_d;
      down_q     <= down_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
    end
  end

  assign clklatch = clklatch_q;
  assign clkout   = clkout_q;
  assign buttons  = buttons_q;
  assign up       = up_q;
  assign down     = down_q;
  assign left     = left_q;
  assign right    = right_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a behavioural 4021-style controller drives data and
// each frame is checked against protocol timing and button values derived from rules.
module tb_nes_pad_reader;
  import nes_pkg::*;

  localparam int unsigned DIV         = 4;
  localparam int unsigned LT          = 3;
  localparam int unsigned PT          = 10;
  localparam int unsigned LATCH_CYC   = LT * DIV;
  localparam int unsigned VALID_OFS   = (LT + 14) * DIV + 1;
  localparam int unsigned PERIOD      = (PT + LT + 14) * DIV + 1;
  localparam int unsigned FIRST_LATCH = PT * DIV;
  localparam int unsigned TIMEOUT     = 400;

  logic       inputclk = 1'b0;
  logic       reset_b  = 1'b1;
  logic       data;
  logic       clklatch, clkout, valid;
  logic       up, down, left, right;
  logic [7:0] buttons;

  logic [7:0]  pad     = 8'h00;
  logic        ovr_en  = 1'b0;
  logic        ovr_val = 1'b1;
  int unsigned ctl_idx = 8;
  int unsigned cyc     = 0;
  int          errors  = 0;
  int          checks  = 0;
  logic [7:0]  model_btn = 8'h00;
  int unsigned rise_cyc  = 0;
  int unsigned prev_rise = 0;
  int unsigned wait_cyc  = 0;

  nes_pad_reader #(
    .TICK_DIV    (DIV),
    .LATCH_TICKS (LT),
    .POLL_TICKS  (PT)
  ) dut (
    .inputclk (inputclk),
    .reset_b  (reset_b),
    .data     (data),
    .clklatch (clklatch),
    .clkout   (clkout),
    .buttons  (buttons),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .valid    (valid)
  );

  always #5 inputclk = ~inputclk;

  always @(posedge inputclk) cyc <= cyc + 1;

  // Controller: latch presents bit 0, each clkout rise advances one bit, then idle high.
  always @(posedge clklatch or posedge clkout) begin
    if (clklatch) ctl_idx = 0;
    else if (ctl_idx < 8) ctl_idx = ctl_idx + 1;
  end

  assign data = ovr_en ? ovr_val : ((ctl_idx < 8) ? ~pad[ctl_idx[2:0]] : 1'b1);

  function automatic logic [3:0] dpad_ref(input logic [7:0] b);
    logic [3:0] r;
    r[0] = b[BTN_UP]    && !b[BTN_DOWN];
    r[1] = b[BTN_DOWN]  && !b[BTN_UP];
    r[2] = b[BTN_LEFT]  && !b[BTN_RIGHT];
    r[3] = b[BTN_RIGHT] && !b[BTN_LEFT];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input string tag, input bit glitch);
    int unsigned n;
    int unsigned latch_hi, pulses, hi_len, lo_len, valid_cnt;
    int          valid_at;
    bit          overlap, len_ok, hold_ok, prev_clk;
    logic [7:0]  exp_btn, got_btn;
    logic [3:0]  got_dpad;
    n = 0; latch_hi = 0; pulses = 0; hi_len = 0; lo_len = 0; valid_cnt = 0;
    valid_at = -1; overlap = 0; len_ok = 1; hold_ok = 1; prev_clk = 0;
    exp_btn = pad; got_btn = 8'h00; got_dpad = 4'h0;

    while (clklatch !== 1'b1 && n < TIMEOUT) begin
      @(negedge inputclk);
      n++;
      if (buttons !== model_btn || valid === 1'b1) hold_ok = 0;
    end
    wait_cyc = n;
    chk({tag, ":latch_seen"}, {31'd0, clklatch}, 32'd1);
    prev_rise = rise_cyc;
    rise_cyc  = cyc;

    for (int unsigned o = 0; o <= VALID_OFS + 6; o++) begin
      if (o > 0) @(negedge inputclk);
      if (clklatch && clkout) overlap = 1;
      if (clklatch) latch_hi++;
      if (valid === 1'b1) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = int'(o);
          got_btn  = buttons;
          got_dpad = {right, left, down, up};
        end
      end else if (valid_at < 0 && buttons !== model_btn) begin
        hold_ok = 0;
      end
      if (clkout && !prev_clk) begin
        pulses++;
        if (pulses > 1 && lo_len != DIV) len_ok = 0;
        hi_len = 1;
      end else if (clkout) begin
        hi_len++;
      end else if (prev_clk) begin
        if (hi_len != DIV) len_ok = 0;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      prev_clk = clkout;
      // Asynchronous data changes: bit 0 during latch, bits 1..7 twice inside each clkout high.
      if (glitch && o == 1) begin
        #2 ovr_val = 1'($urandom_range(1));
        exp_btn[0] = ~ovr_val;
      end
      if (glitch && clkout && hi_len == 1 && pulses >= 1 && pulses <= 7) begin
        #2 ovr_val = 1'($urandom_range(1));
        #4 ovr_val = 1'($urandom_range(1));
        exp_btn[pulses] = ~ovr_val;
      end
    end

    chk({tag, ":latch_len"},   latch_hi, LATCH_CYC);
    chk({tag, ":pulses"},      pulses, 32'd7);
    chk({tag, ":clk_lengths"}, {31'd0, len_ok}, 32'd1);
    chk({tag, ":overlap"},     {31'd0, overlap}, 32'd0);
    chk({tag, ":valid_at"},    valid_at, VALID_OFS);
    chk({tag, ":valid_cnt"},   valid_cnt, 32'd1);
    chk({tag, ":buttons"},     {24'd0, got_btn}, {24'd0, exp_btn});
    chk({tag, ":dpad"},        {28'd0, got_dpad}, {28'd0, dpad_ref(exp_btn)});
    chk({tag, ":hold_before"}, {31'd0, hold_ok}, 32'd1);
    chk({tag, ":hold_after"},  {24'd0, buttons}, {24'd0, exp_btn});
    model_btn = exp_btn;
  endtask

  initial begin
    int unsigned n, p;
    bit          prevc, vseen;

    #1 reset_b = 1'b0;
    repeat (3) @(negedge inputclk);
    chk("reset_clklatch", {31'd0, clklatch}, 32'd0);
    chk("reset_clkout",   {31'd0, clkout}, 32'd0);
    chk("reset_valid",    {31'd0, valid}, 32'd0);
    chk("reset_buttons",  {24'd0, buttons}, 32'd0);
    chk("reset_dpad",     {28'd0, up, down, left, right}, 32'd0);

    // Disconnected pad: data idles high throughout.
    #2 reset_b = 1'b1;
    pad = 8'h00;
    frame("disc", 1'b0);
    chk("disc_first_latch", wait_cyc, FIRST_LATCH);

    pad = 8'h81;
    frame("a_right", 1'b0);
    chk("a_right_period", rise_cyc - prev_rise, PERIOD);

    pad = 8'h30;
    frame("up_down", 1'b0);
    chk("up_down_period", rise_cyc - prev_rise, PERIOD);

    // Abort a frame with reset during the bit-4 clock-high phase.
    pad = 8'h5A;
    n = 0;
    while (clklatch !== 1'b1 && n < TIMEOUT) begin @(negedge inputclk); n++; end
    p = 0; n = 0; prevc = clkout;
    while (p < 4 && n < TIMEOUT) begin
      @(negedge inputclk);
      n++;
      if (clkout && !prevc) p++;
      prevc = clkout;
    end
    chk("rst_reach_bit4", p, 32'd4);
    #2 reset_b = 1'b0;
    #1;
    chk("rst_clklatch", {31'd0, clklatch}, 32'd0);
    chk("rst_clkout",   {31'd0, clkout}, 32'd0);
    chk("rst_valid",    {31'd0, valid}, 32'd0);
    chk("rst_buttons",  {24'd0, buttons}, 32'd0);
    chk("rst_dpad",     {28'd0, up, down, left, right}, 32'd0);
    vseen = 0;
    repeat (5) begin
      @(negedge inputclk);
      if (valid === 1'b1) vseen = 1;
    end
    chk("rst_no_valid", {31'd0, vseen}, 32'd0);
    #2 reset_b = 1'b1;
    model_btn = 8'h00;

    pad = 8'h10;
    frame("btn10", 1'b0);
    chk("rst_first_latch", wait_cyc, FIRST_LATCH);

    pad = 8'h40;
    frame("btn40", 1'b0);
    chk("btn40_period", rise_cyc - prev_rise, PERIOD);

    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    frame("async", 1'b1);
    chk("async_period", rise_cyc - prev_rise, PERIOD);
    ovr_en = 1'b0;

    for (int i = 0; i < 4; i++) begin
      pad = 8'($urandom);
      frame("rand", 1'b0);
      chk("rand_period", rise_cyc - prev_rise, PERIOD);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
